// File: rtl/priority_encoder_8x3.sv
// priority_encoder_8x3: stores a request vector and emits the index of each set bit, one per handshake
module priority_encoder_8x3 #(
  parameter int WIDTH = 8,
  parameter int CODE_W = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WIDTH-1:0]  din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CODE_W-1:0] dout,
  output logic              dout_last,
  output logic              err_zero
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] pending, pending_d;
  logic [CODE_W-1:0] idx;
  logic one_hot, fire_in, fire_out;
  // scan toward the highest-priority bit so the last hit wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = MSB_FIRST ? i : WIDTH - 1 - i;
      if (pending[j]) idx = CODE_W'(j);
    end
  end
  assign one_hot    = (pending & (pending - WIDTH'(1))) == '0;
  assign din_ready  = state == IDLE && !rst;
  assign dout_valid = state == SERVE;
  assign dout       = dout_valid ? idx : '0;
  assign dout_last  = dout_valid && one_hot;
  assign fire_in    = din_valid && din_ready;
  assign fire_out   = dout_valid && dout_ready;
  // next state: load a nonzero vector, retire bits, return to idle after the last code
  always_comb begin
    state_d   = fire_in && din != '0 ? SERVE : fire_out && dout_last ? IDLE : state;
    pending_d = fire_in ? din : fire_out ? pending & ~(WIDTH'(1) << idx) : pending;
  end
  // state, pending vector and the dropped-vector pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      err_zero <= 1'b0;
    end else begin
      state    <= state_d;
      pending  <= pending_d;
      err_zero <= fire_in && din == '0;
    end
  end
endmodule

// File: tb/tb_priority_encoder_8x3.sv
// tb_priority_encoder_8x3: directed vectors for the sequential priority encoder
module tb_priority_encoder_8x3;
  logic clk = 0, rst = 1;
  logic din_valid = 0, dout_ready = 0, din_ready, dout_valid, dout_last, err_zero;
  logic [7:0] din = '0;
  logic [2:0] dout;
  logic din_valid2 = 0, dout_ready2 = 1, din_ready2, dout_valid2, dout_last2, err_zero2;
  logic [7:0] din2 = '0;
  logic [2:0] dout2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  priority_encoder_8x3 dut (.clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_last(dout_last), .err_zero(err_zero));
  priority_encoder_8x3 #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .din_valid(din_valid2),
    .din_ready(din_ready2), .din(din2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .dout(dout2), .dout_last(dout_last2), .err_zero(err_zero2));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic code(input string tag, input int v, input int c, input int l);
    check({tag, " valid"}, dout_valid, v);
    check({tag, " code"}, dout, c);
    check({tag, " last"}, dout_last, l);
  endtask
  initial begin
    tick;
    tick;
    check("reset din_ready", din_ready, 0);
    code("reset", 0, 0, 0);
    check("reset err_zero", err_zero, 0);
    rst = 0;
    #1;
    check("post-reset din_ready", din_ready, 1);
    din = 8'hA4; din_valid = 1; dout_ready = 1;
    tick;
    din_valid = 0;
    check("a4 din_ready", din_ready, 0);
    code("a4 #0", 1, 2, 0);
    tick;
    code("a4 #1", 1, 5, 0);
    tick;
    code("a4 #2", 1, 7, 1);
    tick;
    code("a4 done", 0, 0, 0);
    check("a4 din_ready again", din_ready, 1);
    din2 = 8'hA4; din_valid2 = 1;
    tick;
    din_valid2 = 0;
    check("msb #0", dout2, 7); check("msb #0 last", dout_last2, 0);
    tick;
    check("msb #1", dout2, 5); check("msb #1 last", dout_last2, 0);
    tick;
    check("msb #2", dout2, 2); check("msb #2 last", dout_last2, 1);
    tick;
    check("msb done", dout_valid2, 0);
    din = 8'h18; din_valid = 1; dout_ready = 0;
    tick;
    din_valid = 0;
    for (int i = 0; i < 5; i++) begin
      code("stall hold", 1, 3, 0);
      tick;
    end
    dout_ready = 1;
    #1;
    code("stall release", 1, 3, 0);
    tick;
    code("stall second", 1, 4, 1);
    tick;
    code("stall done", 0, 0, 0);
    din = 8'h00; din_valid = 1;
    tick;
    din_valid = 0;
    check("zero err", err_zero, 1);
    check("zero din_ready", din_ready, 1);
    code("zero no output", 0, 0, 0);
    tick;
    check("zero err one cycle", err_zero, 0);
    check("zero still idle", dout_valid, 0);
    din = 8'hFF; din_valid = 1;
    tick;
    din_valid = 0;
    for (int i = 0; i < 8; i++) begin
      code("ff seq", 1, i, i == 7);
      tick;
    end
    code("ff done", 0, 0, 0);
    din = 8'hFF; din_valid = 1;
    tick;
    din_valid = 0;
    code("rst-mid #0", 1, 0, 0);
    tick;
    code("rst-mid #1", 1, 1, 0);
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    code("rst-mid after", 0, 0, 0);
    check("rst-mid din_ready", din_ready, 1);
    din = 8'h80; din_valid = 1;
    tick;
    din_valid = 0;
    code("single 80", 1, 7, 1);
    tick;
    code("single done", 0, 0, 0);
    din = 8'h01; din_valid = 1;
    tick;
    din = 8'h80;
    code("b2b first", 1, 0, 1);
    check("b2b blocked", din_ready, 0);
    tick;
    code("b2b idle gap", 0, 0, 0);
    check("b2b gap ready", din_ready, 1);
    tick;
    din_valid = 0;
    code("b2b second", 1, 7, 1);
    tick;
    code("b2b done", 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
